// File: rtl/cmdreg_pkg.sv
// Shared constants, state encoding and slice helper for the command register arbiter.
package cmdreg_pkg;

    localparam int unsigned NREQ_DEF  = 2;
    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Low bit of producer idx's slice within the packed wr_data bus.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_priority.sv
// Combinational round-robin picker: first eligible index at or above ptr, wrapping.
module rr_priority #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  win_onehot,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        any        = 1'b0;
        // k is the search distance from ptr; the inner loop keeps every bit select constant.
        for (int unsigned k = 0; k < NREQ; k++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!any && eligible[i] && (i == (32'(ptr) + k) % NREQ)) begin
                    any           = 1'b1;
                    win_onehot[i] = 1'b1;
                    win_idx       = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/cmdreg_arbiter.sv
// Shared command register with round-robin write arbitration and avail/ack read handshake.
module cmdreg_arbiter
    import cmdreg_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [NREQ-1:0]         wr,
    input  logic [NREQ*WIDTH-1:0]   wr_data,
    output logic [NREQ-1:0]         grant,
    output logic                    data_avail,
    output logic [WIDTH-1:0]        cmd_data,
    input  logic                    cmd_ack,
    output logic [CNT_W-1:0]        cmd_count
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [NREQ-1:0]  armed_q, armed_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  win_onehot;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;

    assign eligible = wr & armed_q;

    rr_priority #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .eligible   (eligible),
        .ptr        (ptr_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .any        (win_any)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        grant_d = '0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        // A dropped strobe re-arms its producer regardless of register state.
        armed_d = armed_q | ~wr;
        unique case (state_q)
            ST_EMPTY: begin
                if (win_any) begin
                    state_d = ST_FULL;
                    grant_d = win_onehot;
                    armed_d = (armed_q | ~wr) & ~win_onehot;
                    ptr_d   = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
                    cnt_d   = cnt_q + CNT_W'(1);
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (win_onehot[i]) begin
                            data_d = wr_data[slice_lo(i, WIDTH) +: WIDTH];
                        end
                    end
                end
            end
            ST_FULL: begin
                if (cmd_ack) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            grant_q <= '0;
            armed_q <= '1;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            armed_q <= armed_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant      = grant_q;
    assign data_avail = (state_q == ST_FULL);
    assign cmd_data   = data_q;
    assign cmd_count  = cnt_q;

endmodule

// File: tb/tb_cmdreg_arbiter.sv
// Directed self-checking bench for cmdreg_arbiter; second instance uses a 4-bit counter.
module tb_cmdreg_arbiter;

    logic        clk;
    logic        nrst;
    logic [1:0]  wr;
    logic [15:0] wr_data;
    logic        cmd_ack;

    logic [1:0]  grant;
    logic        data_avail;
    logic [7:0]  cmd_data;
    logic [15:0] cmd_count;

    logic [1:0]  grant_w;
    logic        data_avail_w;
    logic [7:0]  cmd_data_w;
    logic [3:0]  cmd_count_w;

    int n_checks = 0;
    int n_pass   = 0;

    cmdreg_arbiter dut (
        .clk        (clk),
        .nrst       (nrst),
        .wr         (wr),
        .wr_data    (wr_data),
        .grant      (grant),
        .data_avail (data_avail),
        .cmd_data   (cmd_data),
        .cmd_ack    (cmd_ack),
        .cmd_count  (cmd_count)
    );

    cmdreg_arbiter #(
        .CNT_W (4)
    ) dut_w (
        .clk        (clk),
        .nrst       (nrst),
        .wr         (wr),
        .wr_data    (wr_data),
        .grant      (grant_w),
        .data_avail (data_avail_w),
        .cmd_data   (cmd_data_w),
        .cmd_ack    (cmd_ack),
        .cmd_count  (cmd_count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst    = 1'b0;
        wr      = 2'b00;
        wr_data = 16'h0000;
        cmd_ack = 1'b0;
        #2;
        check("rst_avail", 32'(data_avail), 32'd0);
        check("rst_count", 32'(cmd_count), 32'd0);
        #10;
        nrst = 1'b1;
        tick();

        // Single write, strobe held 6 edges
        wr      = 2'b01;
        wr_data = 16'h003C;
        tick();
        check("sw_grant", 32'(grant), 32'h1);
        check("sw_avail", 32'(data_avail), 32'd1);
        check("sw_data", 32'(cmd_data), 32'h3C);
        check("sw_count", 32'(cmd_count), 32'd1);
        tick();
        check("sw_grant_pulse", 32'(grant), 32'h0);
        check("sw_avail_hold", 32'(data_avail), 32'd1);
        tick();
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        check("sw_ack_empty", 32'(data_avail), 32'd0);
        tick();
        check("sw_no_rewrite_avail", 32'(data_avail), 32'd0);
        check("sw_no_rewrite_grant", 32'(grant), 32'h0);
        tick();
        wr = 2'b00;
        tick();
        check("sw_count_once", 32'(cmd_count), 32'd1);

        // Async reset while FULL with A5
        wr      = 2'b01;
        wr_data = 16'h00A5;
        tick();
        wr = 2'b00;
        check("rst_pre_data", 32'(cmd_data), 32'hA5);
        check("rst_pre_ptr", 32'(dut.ptr_q), 32'd1);
        #2;
        nrst = 1'b0;
        #1;
        check("arst_avail", 32'(data_avail), 32'd0);
        check("arst_data", 32'(cmd_data), 32'd0);
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_count", 32'(cmd_count), 32'd0);
        check("arst_ptr", 32'(dut.ptr_q), 32'd0);
        #1;
        nrst = 1'b1;
        tick();

        // Contention, two rounds; each round must serve 0x11 then 0x22
        for (int r = 0; r < 2; r++) begin
            wr      = 2'b11;
            wr_data = 16'h2211;
            tick();
            check($sformatf("ct%0d_grant0", r), 32'(grant), 32'h1);
            check($sformatf("ct%0d_data0", r), 32'(cmd_data), 32'h11);
            wr = 2'b10;
            tick();
            cmd_ack = 1'b1;
            tick();
            cmd_ack = 1'b0;
            check($sformatf("ct%0d_empty", r), 32'(data_avail), 32'd0);
            tick();
            check($sformatf("ct%0d_grant1", r), 32'(grant), 32'h2);
            check($sformatf("ct%0d_data1", r), 32'(cmd_data), 32'h22);
            wr = 2'b00;
            tick();
            cmd_ack = 1'b1;
            tick();
            cmd_ack = 1'b0;
        end
        check("ct_count", 32'(cmd_count), 32'd4);

        // Ack and a rising write on the same edge
        wr      = 2'b01;
        wr_data = 16'h0040;
        tick();
        check("aw_data40", 32'(cmd_data), 32'h40);
        wr = 2'b00;
        tick();
        cmd_ack = 1'b1;
        wr      = 2'b10;
        wr_data = 16'h4100;
        tick();
        cmd_ack = 1'b0;
        check("aw_gap_avail", 32'(data_avail), 32'd0);
        check("aw_gap_grant", 32'(grant), 32'h0);
        tick();
        check("aw_grant", 32'(grant), 32'h2);
        check("aw_data41", 32'(cmd_data), 32'h41);
        check("aw_count", 32'(cmd_count), 32'd6);
        wr      = 2'b00;
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;

        // Spurious ack while EMPTY
        check("sp_pre_avail", 32'(data_avail), 32'd0);
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        tick();
        check("sp_avail", 32'(data_avail), 32'd0);
        check("sp_count", 32'(cmd_count), 32'd6);
        check("sp_ptr", 32'(dut.ptr_q), 32'd0);

        // Counter wrap: 17 writes after reset
        nrst = 1'b0;
        #2;
        nrst = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            wr      = 2'b01;
            wr_data = 16'(i + 8'h80);
            tick();
            wr      = 2'b00;
            cmd_ack = 1'b1;
            tick();
            cmd_ack = 1'b0;
        end
        check("wrap_count4", 32'(cmd_count_w), 32'd1);
        check("wrap_count16", 32'(cmd_count), 32'd17);
        check("wrap_last_data", 32'(cmd_data_w), 32'h90);
        check("wrap_avail", 32'(data_avail_w), 32'd0);
        check("wrap_grant", 32'(grant_w), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cmdreg_arbiter.md
Name: cmdreg_arbiter

Overview:
Owns the shared command register and arbitrates its write port among NREQ producers (FIFO reader, power-on init sequencer, debug injector).
- Holds one WIDTH-bit command plus an occupancy flag.
- Grants writes round-robin and hands the command to a single consumer (display command executor) via an avail/ack handshake.
- Converts producers' level-held write strobes into exactly one accepted write per strobe.

Parameters:
NREQ, 2, number of producers (2..8)
WIDTH, 8, command width in bits
CNT_W, 16, width of accepted-command counter

Ports:
clk  in  1  system clock
nrst  in  1  reset, asynchronous, active-low
wr  in  NREQ  per-producer write strobe; level, held high with stable data until grant seen
wr_data  in  NREQ*WIDTH  producer data; slice i = bits [i*WIDTH +: WIDTH]
grant  out  NREQ  one-hot, one-cycle pulse: producer i's data was latched
data_avail  out  1  register occupied; broadcast to all producers
cmd_data  out  WIDTH  register contents to consumer
cmd_ack  in  1  consumer pulse: command taken, free register
cmd_count  out  CNT_W  number of accepted writes, wraps

Behaviour:
- Reset (nrst low, async): data_avail=0, cmd_data=0, grant=0, cmd_count=0, rr pointer=0, all armed[i]=1. Takes effect immediately, not at the next edge.
- State is a single occupancy bit: EMPTY (data_avail=0) / FULL (data_avail=1).
- Eligible requester i: wr[i]=1 and armed[i]=1.

EMPTY, at a clk edge with at least one eligible requester:
- Winner i = first eligible index searching from ptr upward, wrapping mod NREQ.
- Same edge: cmd_data<=wr_data slice i; state->FULL; grant<=onehot(i); armed[i]<=0; ptr<=(i+1) mod NREQ; cmd_count<=cmd_count+1 (wraps at 2^CNT_W).
- Latency: winner's wr sampled high at edge N gives data_avail=1, cmd_data valid and grant[i]=1 all in the cycle after N. grant clears at N+1.

FULL:
- No grants. wr ignored except for armed tracking.
- cmd_data is stable until cmd_ack.
- cmd_ack=1 at an edge: state->EMPTY. cmd_data holds its old value (don't-care to consumer).
- Earliest next grant is the following edge. No same-cycle bypass.

cmd_ack while EMPTY: ignored, no state change.

Armed tracking (every edge, any state):
- armed[i]<=1 whenever wr[i]=0.
- A producer must drop wr for at least 1 cycle between commands. A strobe held for many cycles produces exactly one write.

Simultaneous events:
- Several eligible requesters in EMPTY: only the round-robin winner is granted. Losers keep wr high and are served on later EMPTY edges.
- wr rising on the same edge as cmd_ack: not granted that edge (register still FULL at sampling). Granted next edge if still eligible.

Reset mid-transfer:
- The register content is lost.
- A producer still holding wr after reset release is accepted as a new write, because armed resets to 1.

Producers may start a write only when data_avail=0, but must tolerate losing arbitration. They hold wr until grant[i].

Decomposition:
- cmdreg_pkg: default WIDTH/NREQ/CNT_W constants, ST_EMPTY/ST_FULL encodings, and a function for the wr_data slice index.
- One sub-module, rr_priority: combinational round-robin picker.
  - Inputs: eligible vector, ptr.
  - Outputs: one-hot winner, winner index, any flag.
- All state lives in cmdreg_arbiter.

Test Plan:
- Reset: nrst low mid-FULL with cmd_data=8'hA5 -> all outputs 0 immediately (asynchronously, before next edge), ptr=0.
- Single write: wr[0]=1 with data 8'h3C held 6 cycles -> grant=2'b01 for exactly 1 cycle, data_avail=1, cmd_data=8'h3C, cmd_count=1. No second write without wr[0] dropping, even after cmd_ack.
- Contention: wr=2'b11 at once, data0=8'h11, data1=8'h22, consumer acks each command 2 cycles after data_avail -> order 8'h11 then 8'h22, then with wr low for 1 cycle and wr=2'b11 again -> order 8'h11, 8'h22 (ptr alternation verified).
- Ack/write same edge: FULL with 8'h40, cmd_ack and new wr[1] rising (data 8'h41) on the same edge -> data_avail=0 for one cycle, then 8'h41 granted the following edge.
- Spurious ack: cmd_ack pulses while EMPTY -> no change to data_avail, cmd_count, or ptr.
- Counter wrap: CNT_W=4, 17 accepted writes -> cmd_count=1.
